// File: rtl/seq_mult_unit_pkg.sv
// rtl/seq_mult_unit_pkg.sv - shared encodings and defaults for multi-cycle ALU units
package seq_mult_unit_pkg;

    // Defaults shared with the control unit and other multi-cycle units
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    // Multiplier sequencer states; 2'b11 is unused and recovers to idle
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } mult_state_e;

endpackage

// File: rtl/seq_mult_unit_datapath.sv
// rtl/seq_mult_unit_datapath.sv - operand/accumulator registers and shift-add step
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   data1_i,
    input  logic [WIDTH-1:0]   data2_i,
    output logic [2*WIDTH-1:0] acc_next_o
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] mcand_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   mplier_d;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;

    // Accumulator value after the current iteration; also feeds the result load
    assign acc_next_o = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Next-state: load fresh operands, or shift by one bit per step
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load_i) begin
            mcand_d  = {{WIDTH{1'b0}}, data1_i};
            mplier_d = data2_i;
            acc_d    = '0;
        end else if (step_i) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_next_o;
        end
    end

    // Operand and accumulator registers, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/seq_mult_unit.sv
// rtl/seq_mult_unit.sv - multi-cycle unsigned shift-and-add multiplier with busywait stall
module seq_mult_unit
    import seq_mult_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             OVERFLOW,
    output logic             DONE,
    output logic             BUSYWAIT
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_e        state_q;
    mult_state_e        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               done_q;
    logic               done_d;
    logic               load;
    logic               step;
    logic               busy;
    logic [2*WIDTH-1:0] acc_next;

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk        (CLK),
        .rst_n      (RESET),
        .load_i     (load),
        .step_i     (step),
        .data1_i    (DATA1),
        .data2_i    (DATA2),
        .acc_next_o (acc_next)
    );

    // Sequencer: next state, datapath enables, result capture and stall request
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Stall in the same cycle the request is raised
                busy = START;
                if (START) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy  = 1'b1;
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    result_d = acc_next[WIDTH-1:0];
                    ovf_d    = |acc_next[2*WIDTH-1:WIDTH];
                    done_d   = 1'b1;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // START is ignored here; a held request restarts from idle
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset abandons any operation
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign RESULT   = result_q;
    assign OVERFLOW = ovf_q;
    assign DONE     = done_q;
    assign BUSYWAIT = busy;

endmodule

// File: tb/tb_seq_mult_unit.sv
// tb/tb_seq_mult_unit.sv - directed self-checking bench for seq_mult_unit
module tb_seq_mult_unit;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       OVERFLOW;
    logic       DONE;
    logic       BUSYWAIT;

    int tests_run;
    int tests_failed;

    seq_mult_unit #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .RESULT   (RESULT),
        .OVERFLOW (OVERFLOW),
        .DONE     (DONE),
        .BUSYWAIT (BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One full operation: request at a negedge, then 8 RUN cycles, FINISH, back to idle
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic exp_ovf, input bit scramble);
        DATA1 = a;
        DATA2 = b;
        START = 1'b1;
        #1;
        chk({tag, "_busy_req"}, 16'(BUSYWAIT), 16'd1);
        @(negedge CLK);
        START = 1'b0;
        if (scramble) begin
            DATA1 = 8'hFF;
            DATA2 = 8'hFF;
        end
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy_run"}, 16'(BUSYWAIT), 16'd1);
            chk({tag, "_done_run"}, 16'(DONE), 16'd0);
            @(negedge CLK);
        end
        chk({tag, "_done"}, 16'(DONE), 16'd1);
        chk({tag, "_busy_fin"}, 16'(BUSYWAIT), 16'd0);
        chk({tag, "_result"}, 16'(RESULT), 16'(exp_res));
        chk({tag, "_ovf"}, 16'(OVERFLOW), 16'(exp_ovf));
        @(negedge CLK);
        chk({tag, "_done_drop"}, 16'(DONE), 16'd0);
        chk({tag, "_result_hold"}, 16'(RESULT), 16'(exp_res));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_done;
        tests_run    = 0;
        tests_failed = 0;
        RESET = 1'b0;
        START = 1'b0;
        DATA1 = 8'h00;
        DATA2 = 8'h00;

        // Reset held for two cycles
        repeat (2) @(negedge CLK);
        chk("rst_result", 16'(RESULT), 16'h00);
        chk("rst_ovf", 16'(OVERFLOW), 16'd0);
        chk("rst_done", 16'(DONE), 16'd0);
        chk("rst_busy", 16'(BUSYWAIT), 16'd0);
        RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle_result", 16'(RESULT), 16'h00);
            chk("idle_ovf", 16'(OVERFLOW), 16'd0);
            chk("idle_done", 16'(DONE), 16'd0);
            chk("idle_busy", 16'(BUSYWAIT), 16'd0);
        end

        // 13 x 11 = 143 = 0x8F
        run_op("basic", 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0);
        // 0x20 x 0x10 = 0x0200
        run_op("ovf_a", 8'h20, 8'h10, 8'h00, 1'b1, 1'b0);
        // 0xFF x 0xFF = 0xFE01
        run_op("ovf_b", 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
        // 0 x 0xA5 still takes the full 8 RUN cycles
        run_op("zero", 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0);
        // 7 x 9 = 63 with operands corrupted during RUN
        run_op("stable", 8'd7, 8'd9, 8'h3F, 1'b0, 1'b1);

        // Reset in the middle of 0xFF x 0xFF
        DATA1 = 8'hFF;
        DATA2 = 8'hFF;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("midrst_result", 16'(RESULT), 16'h00);
        chk("midrst_busy", 16'(BUSYWAIT), 16'd0);
        chk("midrst_done", 16'(DONE), 16'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("midrst_nodone", 16'(DONE), 16'd0);
            if (i == 1) RESET = 1'b1;
        end
        chk("midrst_ovf", 16'(OVERFLOW), 16'd0);
        run_op("after_rst", 8'd3, 8'd5, 8'h0F, 1'b0, 1'b0);

        // Back-to-back: START held, operands swapped after the first is latched
        DATA1 = 8'd2;
        DATA2 = 8'd3;
        START = 1'b1;
        #1;
        chk("b2b_busy_req", 16'(BUSYWAIT), 16'd1);
        @(negedge CLK);
        DATA1 = 8'd4;
        DATA2 = 8'd5;
        for (int i = 0; i < 19; i++) begin
            exp_done = (i == 8) || (i == 18);
            chk("b2b_done", 16'(DONE), 16'(exp_done));
            chk("b2b_busy", 16'(BUSYWAIT), 16'(!exp_done));
            if (i == 8) chk("b2b_result1", 16'(RESULT), 16'h06);
            if (i == 18) begin
                chk("b2b_result2", 16'(RESULT), 16'h14);
                START = 1'b0;
            end
            @(negedge CLK);
        end
        chk("b2b_idle_done", 16'(DONE), 16'd0);
        chk("b2b_idle_busy", 16'(BUSYWAIT), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
